// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: the bundle between the multicycle controller and the
// MIPS datapath.
//   opcode, mem_ready              : datapath -> controller (IR[31:26], memory done)
//   PCWrite .. PCSource, illegal_op: controller -> datapath mux selects / enables
//   retired                        : controller -> observer, instructions completed
//   trap_vector                    : controller -> datapath, PCSource=11 mux leg
// Modports: master = controller side, slave = datapath side.
interface multicycle_ctrl_if;
    logic [5:0]  opcode;
    logic        mem_ready;
    logic        PCWrite;
    logic        PCWriteCond;
    logic        IorD;
    logic        MemRead;
    logic        MemWrite;
    logic        IRWrite;
    logic        MemtoReg;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ALUOp;
    logic [1:0]  PCSource;
    logic        illegal_op;
    logic [31:0] retired;
    logic [31:0] trap_vector;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal_op, retired, trap_vector
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
               PCSource, illegal_op, retired, trap_vector
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle sequencing controller for the MIPS datapath.
// Steps each instruction through fetch / decode / execute / memory / writeback
// and stalls on mem_ready in FETCH, MEMREAD and MEMWRITE.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : multicycle_ctrl_if.master (opcode, mem_ready in; control word,
//          illegal_op, retired, trap_vector out)
// Parameter TRAP_VECTOR: PC target for illegal opcodes, exported on
// bus.trap_vector for the datapath's PCSource=11 mux leg.
// Optional feature macro: MCTRL_TRAP_EN -- when defined, undefined opcodes
// enter a TRAP state (PC <- TRAP_VECTOR, illegal_op pulse, counted as retired);
// when undefined they fall back to FETCH as an uncounted 2-cycle NOP.
module multicycle_ctrl #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
    input  logic              clk,
    input  logic              rst,
    multicycle_ctrl_if.master bus
);

`ifdef MCTRL_TRAP_EN
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADDR = 4'd2, MEMREAD = 4'd3,
        MEMWB = 4'd4, MEMWRITE = 4'd5, EXEC = 4'd6, RWB = 4'd7,
        BRANCH = 4'd8, JUMP = 4'd9, IEXEC = 4'd10, IWB = 4'd11,
        TRAP = 4'd12
    } state_t;
`else
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADDR = 4'd2, MEMREAD = 4'd3,
        MEMWB = 4'd4, MEMWRITE = 4'd5, EXEC = 4'd6, RWB = 4'd7,
        BRANCH = 4'd8, JUMP = 4'd9, IEXEC = 4'd10, IWB = 4'd11
    } state_t;
`endif

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       illegal;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    state_t      state, next_state;
    logic        retire;       // this edge moves into FETCH from a final state
    logic [31:0] retired_q;
    ctrl_t       c, cg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= FETCH;
            retired_q <= '0;
        end else begin
            state <= next_state;
            if (retire)
                retired_q <= retired_q + 32'd1;   // wraps naturally
        end
    end

    always_comb begin
        c          = '0;
        next_state = FETCH;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                // PC+4 and IR load only on the cycle the word arrives
                c.ir_write  = bus.mem_ready;
                c.pc_write  = bus.mem_ready;
                next_state  = bus.mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                c.alu_src_b = 2'b11;   // branch target precompute
                case (bus.opcode)
                    OP_RTYPE:    next_state = EXEC;
                    OP_LW, OP_SW: next_state = MEMADDR;
                    OP_BEQ:      next_state = BRANCH;
                    OP_J:        next_state = JUMP;
                    OP_ADDI:     next_state = IEXEC;
`ifdef MCTRL_TRAP_EN
                    default:     next_state = TRAP;
`else
                    default:     next_state = FETCH;   // uncounted NOP
`endif
                endcase
            end
            MEMADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                // IR is stable, so the opcode still tells lw from sw here
                next_state  = (bus.opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
                next_state = bus.mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
                retire       = 1'b1;
            end
            MEMWRITE: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
                next_state  = bus.mem_ready ? FETCH : MEMWRITE;
                retire      = bus.mem_ready;
            end
            EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_op    = 2'b10;
                next_state  = RWB;
            end
            RWB: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                retire      = 1'b1;
            end
            BRANCH: begin
                c.alu_src_a     = 1'b1;
                c.alu_op        = 2'b01;
                c.pc_write_cond = 1'b1;
                c.pc_source     = 2'b01;
                retire          = 1'b1;
            end
            JUMP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b10;
                retire      = 1'b1;
            end
            IEXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                next_state  = IWB;
            end
            IWB: begin
                c.reg_write = 1'b1;
                retire      = 1'b1;
            end
`ifdef MCTRL_TRAP_EN
            TRAP: begin
                c.pc_write  = 1'b1;
                c.pc_source = 2'b11;
                c.illegal   = 1'b1;
                retire      = 1'b1;
            end
`endif
            default: ;   // unused encodings: outputs 0, back to FETCH
        endcase
    end

    // every control output is forced low while reset is held
    assign cg = rst ? c : '0;

    assign bus.PCWrite     = cg.pc_write;
    assign bus.PCWriteCond = cg.pc_write_cond;
    assign bus.IorD        = cg.iord;
    assign bus.MemRead     = cg.mem_read;
    assign bus.MemWrite    = cg.mem_write;
    assign bus.IRWrite     = cg.ir_write;
    assign bus.MemtoReg    = cg.mem_to_reg;
    assign bus.RegDst      = cg.reg_dst;
    assign bus.RegWrite    = cg.reg_write;
    assign bus.ALUSrcA     = cg.alu_src_a;
    assign bus.ALUSrcB     = cg.alu_src_b;
    assign bus.ALUOp       = cg.alu_op;
    assign bus.PCSource    = cg.pc_source;
    assign bus.illegal_op  = cg.illegal;
    assign bus.retired     = retired_q;
    assign bus.trap_vector = TRAP_VECTOR;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a table of per-cycle {opcode, mem_ready,
// expected control word, expected retired} records replayed from reset,
// followed by hand sequences for reset abort, counter wrap and illegal opcode.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus ();
    multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

    // control word: {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
    //  MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB[2], ALUOp[2], PCSource[2], illegal_op}
    function automatic logic [16:0] cw(input logic pcw, pcwc, iord, mrd, mwr,
                                       irw, m2r, rdst, rwr, srca,
                                       input logic [1:0] srcb, aluop, pcsrc,
                                       input logic ill);
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca,
                srcb, aluop, pcsrc, ill};
    endfunction

    logic [16:0] W_FRDY, W_FSTL, W_DEC, W_MADDR, W_MRD, W_MWB, W_MWR,
                 W_EXEC, W_RWB, W_BR, W_J, W_IEX, W_IWB, W_TRAP;

    logic [16:0] act;
    assign act = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                  bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst,
                  bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
                  bus.PCSource, bus.illegal_op};

    typedef struct {
        logic [5:0]  op;
        logic        mr;
        logic [16:0] w;
        logic [31:0] r;
    } vec_t;
    vec_t vq[$];

    int checks = 0;
    int failures = 0;

    task automatic add(input logic [5:0] op, input logic mr,
                       input logic [16:0] w, input logic [31:0] r);
        vec_t v;
        v.op = op; v.mr = mr; v.w = w; v.r = r;
        vq.push_back(v);
    endtask

    task automatic chk(input string tag, input int idx,
                       input logic [16:0] w, input logic [31:0] r);
        checks++;
        if (act !== w) begin
            failures++;
            $display("FAIL %s[%0d] ctrl got=%b exp=%b", tag, idx, act, w);
        end
        checks++;
        if (bus.retired !== r) begin
            failures++;
            $display("FAIL %s[%0d] retired got=%h exp=%h", tag, idx, bus.retired, r);
        end
    endtask

    // Starts on a falling edge, drives inputs, checks, ends on the next falling edge.
    task automatic cyc(input string tag, input int idx, input logic [5:0] op,
                       input logic mr, input logic [16:0] w, input logic [31:0] r);
        bus.opcode = op;
        bus.mem_ready = mr;
        #1 chk(tag, idx, w, r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1 chk("reset", 0, '0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        W_FRDY  = cw(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0);
        W_FSTL  = cw(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
        W_DEC   = cw(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
        W_MADDR = cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        W_MRD   = cw(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        W_MWB   = cw(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0);
        W_MWR   = cw(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0);
        W_EXEC  = cw(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0);
        W_RWB   = cw(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0);
        W_BR    = cw(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0);
        W_J     = cw(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0);
        W_IEX   = cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0);
        W_IWB   = cw(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
        W_TRAP  = cw(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b11,1);

        // lw, no stall: 5 cycles, write back only in cycle 5
        add(6'h23,1,W_FRDY,0); add(6'h23,1,W_DEC,0); add(6'h23,1,W_MADDR,0);
        add(6'h23,1,W_MRD,0);  add(6'h23,1,W_MWB,0);
        // sw, 3 stall cycles in MEMWRITE: 7 cycles, MemWrite held 4 cycles
        add(6'h2B,1,W_FRDY,1); add(6'h2B,1,W_DEC,1); add(6'h2B,1,W_MADDR,1);
        add(6'h2B,0,W_MWR,1);  add(6'h2B,0,W_MWR,1); add(6'h2B,0,W_MWR,1);
        add(6'h2B,1,W_MWR,1);
        // beq then j
        add(6'h04,1,W_FRDY,2); add(6'h04,1,W_DEC,2); add(6'h04,1,W_BR,2);
        add(6'h02,1,W_FRDY,3); add(6'h02,1,W_DEC,3); add(6'h02,1,W_J,3);
        // addi, mem_ready low where it must be ignored
        add(6'h08,1,W_FRDY,4); add(6'h08,0,W_DEC,4); add(6'h08,0,W_IEX,4);
        add(6'h08,0,W_IWB,4);
        // R-type with one fetch stall
        add(6'h00,0,W_FSTL,5); add(6'h00,1,W_FRDY,5); add(6'h00,1,W_DEC,5);
        add(6'h00,0,W_EXEC,5); add(6'h00,0,W_RWB,5);
        // lw with one MEMREAD stall
        add(6'h23,1,W_FRDY,6); add(6'h23,1,W_DEC,6); add(6'h23,1,W_MADDR,6);
        add(6'h23,0,W_MRD,6);  add(6'h23,1,W_MRD,6); add(6'h23,1,W_MWB,6);
        add(6'h00,0,W_FSTL,7);

        bus.opcode = '0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset();

        foreach (vq[i]) cyc("vec", i, vq[i].op, vq[i].mr, vq[i].w, vq[i].r);

        // reset dropped in MEMREAD of a lw: outputs die at once, count cleared
        cyc("abort", 0, 6'h23, 1, W_FRDY, 7);
        cyc("abort", 1, 6'h23, 1, W_DEC, 7);
        cyc("abort", 2, 6'h23, 1, W_MADDR, 7);
        bus.mem_ready = 1'b0;
        #1 chk("abort", 3, W_MRD, 7);
        #1 rst = 1'b0;
        #1 chk("abort_rst", 4, '0, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) cyc("abort_post", k, 6'h23, 0, W_FSTL, 0);

        // retired wrap on an R-type
        do_reset();
        bus.opcode = 6'h00;
        bus.mem_ready = 1'b1;
        #1 chk("wrap", 0, W_FRDY, 0);
        force dut.retired_q = 32'hFFFF_FFFF;
        #1 release dut.retired_q;
        @(negedge clk);
        cyc("wrap", 1, 6'h00, 1, W_DEC, 32'hFFFF_FFFF);
        cyc("wrap", 2, 6'h00, 1, W_EXEC, 32'hFFFF_FFFF);
        cyc("wrap", 3, 6'h00, 1, W_RWB, 32'hFFFF_FFFF);
        cyc("wrap", 4, 6'h00, 0, W_FSTL, 0);

        // undefined opcode 0x3F
        do_reset();
        cyc("illegal", 0, 6'h3F, 1, W_FRDY, 0);
        cyc("illegal", 1, 6'h3F, 1, W_DEC, 0);
`ifdef MCTRL_TRAP_EN
        cyc("illegal", 2, 6'h3F, 1, W_TRAP, 0);
        cyc("illegal", 3, 6'h00, 0, W_FSTL, 1);
`else
        cyc("illegal", 2, 6'h3F, 0, W_FSTL, 0);
        cyc("illegal", 3, 6'h3F, 0, W_FSTL, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle sequencing controller for the MIPS datapath. It replaces the single-cycle decode-only control unit with a state machine that steps each instruction through fetch, decode, execute, memory and writeback. This lets one shared memory and one ALU be reused across cycles, and it stalls on a memory-ready handshake. It sits between the instruction register's opcode field and the datapath mux and enable inputs (PC, memory, IR, register file, ALU control).

## Interface
Parameters:
- TRAP_VECTOR, 32'h0000_0080, PC loaded on an illegal opcode; the datapath's PCSource=11 mux leg uses it (`MCTRL_TRAP_EN` only).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- opcode  in  6  IR[31:26]; sampled in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if ALU Zero.
- IorD  out  1  memory address: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  IR load.
- MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR.
- RegDst  out  1  write register: 0=rt, 1=rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  0=PC, 1=A.
- ALUSrcB  out  2  00=B, 01=4, 10=sign-extended imm, 11=imm<<2.
- ALUOp  out  2  00=add, 01=sub, 10=funct.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump address, 11=TRAP_VECTOR.
- illegal_op  out  1  one-cycle pulse in TRAP.
- retired  out  32  count of completed instructions.

## Operation
- 4-bit state register. The outputs are a combinational decode of the state, gated by mem_ready where noted. Every output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite and PCWrite are asserted only when mem_ready=1. Go to DECODE on mem_ready; otherwise hold.
- DECODE: ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by opcode:
  - 0x00 → EXEC
  - 0x23 or 0x2B → MEMADDR
  - 0x04 → BRANCH
  - 0x02 → JUMP
  - 0x08 → IEXEC
  - any other → TRAP, or FETCH when `MCTRL_TRAP_EN` is absent.
- MEMADDR: ALUSrcA=1, ALUSrcB=10. Go to MEMREAD for 0x23, MEMWRITE for 0x2B. The opcode is re-read from the IR, which stays stable.
- MEMREAD: MemRead=1, IorD=1. Hold until mem_ready, then go to MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Go to FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Hold until mem_ready, then go to FETCH. MemWrite stays high through the stall.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Go to RWB.
- RWB: RegWrite=1, RegDst=1. Go to FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. Go to FETCH.
- JUMP: PCWrite=1, PCSource=10. Go to FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to IWB.
- IWB: RegWrite=1, RegDst=0. Go to FETCH.
- Unused state encodings go to FETCH on the next edge with all outputs 0.
- retired increments on each edge that moves into FETCH from a final state (MEMWB, MEMWRITE, RWB, BRANCH, JUMP, IWB, TRAP). It wraps from FFFF_FFFF to 0.

## Timing
- Reset: rst low forces state=FETCH and retired=0 immediately, and gates every control output to 0 while asserted. The first fetch strobe appears in the cycle after rst rises.
- Reset mid-instruction aborts it with no write strobe after the assertion; retired does not count it.
- Cycles per instruction with mem_ready held high: R-type 4, lw 5, sw 4, beq 3, j 3, addi 4, trap 3.
- Each low mem_ready cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. During the stall, strobes are held and no other enable is asserted.
- mem_ready is ignored in every other state.

## Configuration
- `MCTRL_TRAP_EN` defined:
  - Undefined opcodes enter TRAP: PCWrite=1, PCSource=11, illegal_op=1 for one cycle, then FETCH.
  - The instruction counts as retired.
- `MCTRL_TRAP_EN` undefined:
  - TRAP state is absent.
  - Undefined opcodes leave DECODE straight to FETCH as a 2-cycle NOP and are not counted.
  - illegal_op is tied to 0 and PCSource never equals 11.

## Test plan
- Reset then lw (0x23), mem_ready=1: states FETCH, DECODE, MEMADDR, MEMREAD, MEMWB. RegWrite=1 and MemtoReg=1 only in cycle 5; retired=1 after it.
- sw (0x2B) with mem_ready low for 3 cycles in MEMWRITE: MemWrite high for 4 consecutive cycles, instruction takes 7 cycles, no RegWrite.
- beq (0x04) then j (0x02): PCWriteCond=1 with PCSource=01 in cycle 3, then PCWrite=1 with PCSource=10 in cycle 6; retired=2.
- Opcode 0x3F: with `MCTRL_TRAP_EN`, illegal_op pulses in cycle 3 with PCSource=11 and retired=1; without it, the next FETCH is at cycle 3 and retired=0.
- rst dropped during MEMREAD of lw: all outputs 0 immediately, retired=0, and no RegWrite after rst rises until a new instruction's writeback.
- Preload retired to FFFF_FFFF via force, run R-type (0x00): retired=0 after RWB, and the instruction takes 4 cycles.
